// File: rtl/multi_cycle_adder.sv
// ---------------------------------------------------------------------------
// multi_cycle_adder
//
// Purpose:
//   Ripple adder that processes CHUNK bits per clock.
//   A full WIDTH-bit operation takes N = WIDTH/CHUNK RUN cycles.
//   The operands are captured when the operation starts, so later changes on
//   A, B, Cin (or sub) have no effect on an operation that is running.
//   S, Cout and V change only when an operation completes, so they never
//   show a partial result.
//
// Optional feature (compile-time macro SUBTRACT_EN):
//   Adds a 'sub' input.
//   With sub=1 the result is A + ~B + ~Cin, which equals A - B - Cin.
//   In that mode Cout=1 means no borrow occurred.
//
// Parameters:
//   WIDTH  operand and sum width in bits. It must be a multiple of CHUNK.
//   CHUNK  number of bits added per clock.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  requests a new operation. Accepted in IDLE or DONE, ignored in RUN.
//   A, B   operands (WIDTH bits each)
//   Cin    carry-in. It acts as borrow-in when subtracting.
//   sub    subtract select. Present only when SUBTRACT_EN is defined.
//   busy   high while an operation is in progress
//   done   one-cycle completion pulse
//   S      registered sum
//   Cout   registered carry-out
//   V      registered two's-complement overflow flag
// ---------------------------------------------------------------------------

// CHUNK-bit adder slice. The FSM reuses it once per RUN cycle.
module mca_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
endmodule

module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // B after optional inversion
    logic [WIDTH-1:0] work_q;   // chunks finished so far
    logic             carry_q;  // carry between chunks
    logic [CW-1:0]    k_q;      // index of the chunk being added

    // Subtraction is folded into the operands at capture time.
    // After that, the datapath is a plain adder.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
`ifdef SUBTRACT_EN
    assign b_eff   = sub ? ~B   : B;
    assign cin_eff = sub ? ~Cin : Cin;
`else
    assign b_eff   = B;
    assign cin_eff = Cin;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             cout_chunk;

    assign a_chunk = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(k_q)*CHUNK +: CHUNK];

    mca_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    // Working result including the chunk being produced this cycle.
    // On the last chunk this is the full sum and is loaded straight into S.
    logic [WIDTH-1:0] work_nxt;
    always_comb begin
        work_nxt = work_q;
        work_nxt[int'(k_q)*CHUNK +: CHUNK] = sum_chunk;
    end

    // Carry into the MSB is recovered as s_msb ^ a_msb ^ b_msb.
    // XOR-ing it with the carry out of the MSB gives the overflow flag.
    // This also works when CHUNK == 1.
    logic v_nxt;
    assign v_nxt = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ cout_chunk;

    logic last_chunk;
    assign last_chunk = (k_q == K_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE.
                // This allows back-to-back operations.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        work_q  <= '0;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    work_q  <= work_nxt;
                    carry_q <= cout_chunk;
                    if (last_chunk) begin
                        S     <= work_nxt;
                        Cout  <= cout_chunk;
                        V     <= v_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k_q   <= '0;
                        state <= DONE;
                    end else begin
                        k_q   <= k_q + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Testbench for multi_cycle_adder with WIDTH=16 and CHUNK=4.
// It uses directed cases plus $urandom operations.
// Each result is checked against an integer-arithmetic reference model.
module tb_multi_cycle_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             sub = 1'b0;
    logic             busy, done, Cout, V;
    logic [WIDTH-1:0] S;

    int n_chk  = 0;
    int n_fail = 0;

    // Last completed result. S, Cout and V must hold these values until the
    // next completion.
    logic [WIDTH-1:0] prev_s = '0;
    logic             prev_c = 1'b0;
    logic             prev_v = 1'b0;

    multi_cycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SUBTRACT_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model written as plain integer arithmetic.
    // Overflow is defined as the signed result falling outside the 16-bit range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb, output logic [15:0] s, output logic co,
                         output logic v);
        int ua, ub, u, sa, sbv, sr;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sbv = $signed(b);
        if (sb) begin
            u  = ua - ub - int'(cin);
            co = (u >= 0);
            sr = sa - sbv - int'(cin);
        end else begin
            u  = ua + ub + int'(cin);
            co = (u > 32'hFFFF);
            sr = sa + sbv + int'(cin);
        end
        s = u[15:0];
        v = (sr > 32767) || (sr < -32768);
    endtask

    // Runs one complete operation and checks every cycle of it.
    // Operands are scrambled and start is pulsed during RUN; neither may
    // affect the result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb);
        logic [15:0] es;
        logic        ec, ev;
        model(a, b, cin, sb, es, ec, ev);
        A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("op_busy_start", busy, 1'b1);
        chk("op_done_start", done, 1'b0);
        for (int c = 1; c <= N; c++) begin
            @(posedge clk); #1;
            if (c < N) begin
                chk("run_done", done, 1'b0);
                chk("run_busy", busy, 1'b1);
                chk("run_S_hold", S, prev_s);
                chk("run_C_hold", Cout, prev_c);
            end else begin
                chk("fin_done", done, 1'b1);
                chk("fin_busy", busy, 1'b0);
                chk("fin_S", S, es);
                chk("fin_Cout", Cout, ec);
                chk("fin_V", V, ev);
            end
            if (c == 1) begin
                A = 16'($urandom);
                B = 16'($urandom);
                Cin = 1'($urandom);
                sub = 1'($urandom);
            end
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
        end
        @(posedge clk); #1;
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_S", S, es);
        prev_s = es;
        prev_c = ec;
        prev_v = ev;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_S", S, 16'h0000);
        chk("rst_Cout", Cout, 1'b0);
        chk("rst_V", V, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed cases
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("d1_S", S, 16'h5555);
        chk("d1_C", Cout, 1'b0);
        chk("d1_V", V, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("d2_S", S, 16'h0000);
        chk("d2_C", Cout, 1'b1);
        chk("d2_V", V, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        chk("d3_S", S, 16'h8000);
        chk("d3_C", Cout, 1'b0);
        chk("d3_V", V, 1'b1);

        // Back-to-back with start held high: done every 5 cycles.
        // The change to A during the second operation must be ignored.
        A = 16'h0001; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            chk("b2b_done", done, ((c % 5) == 4) ? 1'b1 : 1'b0);
            chk("b2b_busy", busy, ((c % 5) == 4) ? 1'b0 : 1'b1);
            if ((c % 5) == 4) chk("b2b_S", S, 16'h0002);
            if (c == 6) A = 16'hFFFF;
            if (c == 7) A = 16'h0001;
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", busy, 1'b0);
        prev_s = 16'h0002; prev_c = 1'b0; prev_v = 1'b0;

        // Reset in the middle of RUN: no done pulse and cleared outputs
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_S", S, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("aborted_done", done, 1'b0);
            chk("aborted_busy", busy, 1'b0);
        end
        prev_s = '0; prev_c = 1'b0; prev_v = 1'b0;
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        chk("after_rst_S", S, 16'h0007);

`ifdef SUBTRACT_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        chk("sub1_S", S, 16'hFFFE);
        chk("sub1_C", Cout, 1'b0);
        chk("sub1_V", V, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        chk("sub2_S", S, 16'h7FFF);
        chk("sub2_C", Cout, 1'b1);
        chk("sub2_V", V, 1'b1);
`endif

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
`ifdef SUBTRACT_EN
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`else
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
